// File: rtl/fpu_mul_v4sf_seq.sv
// Packed 4-lane binary32 sequencer around the 2-stage single-lane multiplier.
// Define FPU_MUL_V4SF_HALF_EN to add packed binary16 lanes selected by opHalf.
module fpu_mul_v4sf_seq (
   input  logic         clock,
   input  logic         reset,
   input  logic         exHold,
   input  logic         req,
   input  logic         opHalf,
   input  logic [127:0] regValRs,
   input  logic [127:0] regValRt,
   output logic [127:0] regValRo,
   output logic         busy,
   output logic         ok,
   output logic [31:0]  mulValRs,
   output logic [31:0]  mulValRt,
   output logic         mulHold,
   input  logic [31:0]  mulValRo
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t       state, stateNext;
   logic [1:0]   issueCnt;
   logic [127:0] opRs, opRt;
   logic         tagVld_p0, tagVld_p1;
   logic [1:0]   tagLane_p0, tagLane_p1;
   logic         accept, issuing, lastCapture;

`ifdef FPU_MUL_V4SF_HALF_EN
   logic halfMode;

   function automatic logic [31:0] halfToSingle(input logic [15:0] h);
      logic [7:0] expS;
      expS = {3'b000, h[14:10]} + 8'd112;
      if (h[14:10] == 5'd0) return 32'h0000_0000;
      return {h[15], expS, h[9:0], 13'b0};
   endfunction

   function automatic logic [15:0] singleToHalf(input logic [31:0] s);
      logic signed [9:0] expH;
      expH = $signed({2'b00, s[30:23]}) - 10'sd112;
      if (s[30:23] == 8'd0 || expH <= 10'sd0) return 16'h0000;
      if (expH >= 10'sd31) return {s[31], 15'h7C00};
      return {s[31], expH[4:0], s[22:13]};
   endfunction
`else
   logic unusedHalf;
   assign unusedHalf = opHalf;
`endif

   assign busy    = (state != IDLE);
   assign mulHold = exHold;

   always_comb begin
      stateNext   = state;
      accept      = 1'b0;
      issuing     = 1'b0;
      lastCapture = tagVld_p1 && (tagLane_p1 == 2'd3);
      case (state)
         IDLE: begin
            if (req) begin
               accept    = 1'b1;
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            issuing = 1'b1;
            if (issueCnt == 2'd3) stateNext = DRAIN;
         end
         DRAIN: begin
            if (lastCapture) stateNext = DONE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Issue stage: present the selected lane to the multiplier
   always_comb begin
      mulValRs = 32'h0;
      mulValRt = 32'h0;
      if (issuing) begin
`ifdef FPU_MUL_V4SF_HALF_EN
         if (halfMode) begin
            mulValRs = halfToSingle(opRs[{issueCnt, 4'b0} +: 16]);
            mulValRt = halfToSingle(opRt[{issueCnt, 4'b0} +: 16]);
         end else begin
            mulValRs = opRs[{issueCnt, 5'b0} +: 32];
            mulValRt = opRt[{issueCnt, 5'b0} +: 32];
         end
`else
         mulValRs = opRs[{issueCnt, 5'b0} +: 32];
         mulValRt = opRt[{issueCnt, 5'b0} +: 32];
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!exHold && accept) begin
         opRs <= regValRs;
         opRt <= regValRt;
      end
   end

   // Tag pipeline (_p0 -> _p1) tracks the multiplier's two stages; capture at _p1
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         issueCnt   <= 2'd0;
         tagVld_p0  <= 1'b0;
         tagVld_p1  <= 1'b0;
         tagLane_p0 <= 2'd0;
         tagLane_p1 <= 2'd0;
         regValRo   <= '0;
         ok         <= 1'b0;
`ifdef FPU_MUL_V4SF_HALF_EN
         halfMode   <= 1'b0;
`endif
      end else begin
         ok <= 1'b0;
         if (!exHold) begin
            state      <= stateNext;
            tagVld_p0  <= issuing;
            tagLane_p0 <= issueCnt;
            tagVld_p1  <= tagVld_p0;
            tagLane_p1 <= tagLane_p0;
            ok         <= (state == DRAIN) && lastCapture;
            if (accept) begin
               issueCnt <= 2'd0;
               regValRo <= '0;
`ifdef FPU_MUL_V4SF_HALF_EN
               halfMode <= opHalf;
`endif
            end else begin
               if (issuing) issueCnt <= issueCnt + 2'd1;
               if (tagVld_p1) begin
`ifdef FPU_MUL_V4SF_HALF_EN
                  if (halfMode) begin
                     regValRo[{tagLane_p1, 4'b0} +: 16] <= singleToHalf(mulValRo);
                  end else begin
                     regValRo[{tagLane_p1, 5'b0} +: 32] <= mulValRo;
                  end
`else
                  regValRo[{tagLane_p1, 5'b0} +: 32] <= mulValRo;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_mul_v4sf_seq.sv
// Self-checking bench for fpu_mul_v4sf_seq with a behavioural 2-stage multiplier.
module tb_fpu_mul_v4sf_seq;

   logic         clock = 1'b0;
   logic         reset, exHold, req, opHalf;
   logic [127:0] regValRs, regValRt, regValRo;
   logic         busy, ok, mulHold;
   logic [31:0]  mulValRs, mulValRt;
   logic [31:0]  mulValRo = 32'h0;
   logic [31:0]  mulStage = 32'h0;
   int           total = 0;
   int           bad = 0;

   typedef struct {
      logic [127:0] rs;
      logic [127:0] rt;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl [0:7];

   always #5 clock = ~clock;

   fpu_mul_v4sf_seq dut (
      .clock(clock), .reset(reset), .exHold(exHold), .req(req), .opHalf(opHalf),
      .regValRs(regValRs), .regValRt(regValRt), .regValRo(regValRo),
      .busy(busy), .ok(ok), .mulValRs(mulValRs), .mulValRt(mulValRt),
      .mulHold(mulHold), .mulValRo(mulValRo)
   );

   // Truncating binary32 multiply; zero-exponent operands flush to zero
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      int ea = int'(a[30:23]);
      int eb = int'(b[30:23]);
      int e;
      logic [47:0] p;
      logic [22:0] frac;
      logic sgn = a[31] ^ b[31];
      if (ea == 0 || eb == 0) return 32'h0;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p[47]) begin e = e + 1; frac = p[46:24]; end
      else frac = p[45:23];
      if (e <= 0) return 32'h0;
      if (e >= 255) return {sgn, 8'hFF, 23'h0};
      return {sgn, 8'(e), frac};
   endfunction

   function automatic logic [127:0] refVec(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] r;
      for (int n = 0; n < 4; n++) r[32*n +: 32] = fmul(a[32*n +: 32], b[32*n +: 32]);
      return r;
   endfunction

   function automatic logic [31:0] rndF();
      logic [31:0] r;
      if ($urandom_range(7) == 0) return 32'h0;
      r = $urandom;
      r[30:23] = 8'(96 + $urandom_range(62));
      return r;
   endfunction

   // Multiplier model: two stages, frozen by mulHold
   always @(posedge clock) begin
      if (!mulHold) begin
         mulStage <= fmul(mulValRs, mulValRt);
         mulValRo <= mulStage;
      end
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic startOp(input logic [127:0] rs, input logic [127:0] rt, input logic half);
      regValRs = rs;
      regValRt = rt;
      opHalf   = half;
      req      = 1'b1;
      @(posedge clock); #1;
      req = 1'b0;
   endtask

   // k counts cycles after the accept edge; stops when busy drops
   task automatic waitDone(input int hs, input int hl, input bit pulse,
                           output int okAt, output int okCnt, output int busyCnt);
      okAt = -1; okCnt = 0; busyCnt = 0;
      for (int k = 0; k < 60; k++) begin
         if (ok) begin
            okCnt++;
            if (okAt < 0) okAt = k;
         end
         if (!busy) break;
         busyCnt++;
         exHold = (k >= hs && k < hs + hl);
         if (pulse) req = (k == 2) || ok;
         @(posedge clock); #1;
      end
      exHold = 1'b0;
   endtask

   task automatic runVec(input string nm, input vec_t v, input int hs, input int hl,
                         input int expOk, input int expBusy);
      int okAt, okCnt, busyCnt;
      startOp(v.rs, v.rt, 1'b0);
      waitDone(hs, hl, 1'b0, okAt, okCnt, busyCnt);
      check({nm, " okAt"}, okAt, expOk);
      check({nm, " okCnt"}, okCnt, 1);
      check({nm, " busyCycles"}, busyCnt, expBusy);
      check({nm, " result"}, regValRo, v.exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int okAt, okCnt, busyCnt;
      reset = 1'b1; exHold = 1'b0; req = 1'b0; opHalf = 1'b0;
      regValRs = '0; regValRt = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check("reset regValRo", regValRo, 128'h0);
      check("reset busy", busy, 0);
      check("reset ok", ok, 0);
      check("reset mulValRs", mulValRs, 0);
      check("reset mulValRt", mulValRt, 0);

      tbl[0].rs  = {32'h0, 32'h0, 32'h0, 32'h3F800000};
      tbl[0].rt  = {32'h0, 32'h0, 32'h0, 32'h40000000};
      tbl[0].exp = {32'h0, 32'h0, 32'h0, 32'h40000000};
      tbl[1].rs  = {32'h00000000, 32'hC0000000, 32'h3F800000, 32'h40400000};
      tbl[1].rt  = {32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40000000};
      tbl[1].exp = {32'h00000000, 32'hC0C00000, 32'h3F000000, 32'h40C00000};
      for (int i = 2; i < 8; i++) begin
         for (int n = 0; n < 4; n++) begin
            tbl[i].rs[32*n +: 32] = rndF();
            tbl[i].rt[32*n +: 32] = rndF();
         end
         tbl[i].exp = refVec(tbl[i].rs, tbl[i].rt);
      end

      runVec("plain", tbl[0], -1, 0, 6, 7);
      runVec("mixed", tbl[1], -1, 0, 6, 7);
      runVec("hold_issue", tbl[1], 2, 3, 9, 10);
      runVec("hold_done", tbl[1], 6, 2, 6, 9);

      // req during ISSUE and during ok is dropped; held on into the next cycle it is taken
      startOp(tbl[0].rs, tbl[0].rt, 1'b0);
      waitDone(-1, 0, 1'b1, okAt, okCnt, busyCnt);
      check("pulse okAt", okAt, 6);
      check("pulse okCnt", okCnt, 1);
      check("pulse busyCycles", busyCnt, 7);
      check("pulse result", regValRo, tbl[0].exp);
      @(posedge clock); #1;
      check("req_after_ok accepted", busy, 1);
      req = 1'b0;
      waitDone(-1, 0, 1'b0, okAt, okCnt, busyCnt);
      check("req_after_ok okAt", okAt, 6);
      check("req_after_ok result", regValRo, tbl[0].exp);

      repeat (3) @(posedge clock);
      #1 check("idle holds result", regValRo, tbl[0].exp);

      for (int i = 2; i < 8; i++) runVec($sformatf("rand%0d", i), tbl[i], -1, 0, 6, 7);

      startOp(tbl[1].rs, tbl[1].rt, 1'b0);
      repeat (3) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midreset regValRo", regValRo, 128'h0);
      check("midreset busy", busy, 0);
      check("midreset ok", ok, 0);
      check("midreset mulValRs", mulValRs, 0);
      runVec("after_reset", tbl[0], -1, 0, 6, 7);

`ifdef FPU_MUL_V4SF_HALF_EN
      startOp({64'hDEADBEEF_CAFEF00D, 16'h0000, 16'hBC00, 16'h7800, 16'h3C00},
              {64'h12345678_9ABCDEF0, 16'h3C00, 16'h3C00, 16'h7800, 16'h4000}, 1'b1);
      waitDone(-1, 0, 1'b0, okAt, okCnt, busyCnt);
      check("half okAt", okAt, 6);
      check("half result", regValRo, {64'h0, 16'h0000, 16'hBC00, 16'h7C00, 16'h4000});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
